// File: rtl/rx_frame_ctrl_pkg.sv
// ============================================================================
// Module      : rx_frame_ctrl_pkg
// Description : Shared state encoding and default sync marker for rx_frame_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rx_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    localparam logic [31:0] c_sync_word_default = 32'h1ACF_FC1D;

endpackage

`default_nettype wire

// File: rtl/rx_frame_ctrl_popcount32.sv
// ============================================================================
// Module      : popcount32
// Description : Combinational population count of a 32-bit vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module popcount32 (
    input  logic [31:0] i_data,
    output logic [5:0]  o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < 32; i++) begin
            o_count = o_count + 6'(i_data[i]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/rx_frame_ctrl.sv
// ============================================================================
// Module      : rx_frame_ctrl
// Description : Sync-marker hunt, length parse and payload byte assembly
//               with a one-deep output register and backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_frame_ctrl
    import rx_frame_ctrl_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD = c_sync_word_default,
    parameter int          MAX_ERR   = 2,
    parameter int          MAX_BYTES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        sync_hit,
    output logic        len_err,
    output logic [15:0] frame_cnt
);

    localparam logic [5:0] c_max_err   = 6'(MAX_ERR);
    localparam logic [8:0] c_max_bytes = 9'(MAX_BYTES);

    state_t      r_state;
    // The oldest of the 32 bits is shifted out before it is ever compared.
    logic [30:0] r_sr;
    logic [5:0]  r_fill;
    logic [7:0]  r_acc;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_byte_cnt;
    logic        r_out_valid;
    logic        r_out_last;
    logic [7:0]  r_out_data;
    logic        r_sync_hit;
    logic        r_len_err;
    logic [15:0] r_frame_cnt;

    logic [31:0] w_cand;
    logic [5:0]  w_dist;
    logic        w_match;
    logic [7:0]  w_next_acc;
    logic        w_len_bad;
    logic        w_stall;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_out_hs;

    assign w_cand = {r_sr, in_data};

    popcount32 u_popcount32 (
        .i_data  (w_cand ^ SYNC_WORD),
        .o_count (w_dist)
    );

    assign w_match    = (r_fill >= 6'd31) && (w_dist <= c_max_err);
    assign w_next_acc = {r_acc[6:0], in_data};
    assign w_len_bad  = (w_next_acc == 8'd0) || ({1'b0, w_next_acc} > c_max_bytes);
    // Only the byte-completing bit has to wait for the output register to free up.
    assign w_stall    = r_out_valid && !out_ready && (r_bit_cnt == 3'd7);
    assign w_in_ready = !rst && !((r_state == PAYLOAD) && w_stall);
    assign w_accept   = in_valid && w_in_ready;
    assign w_out_hs   = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HUNT;
            r_sr        <= '0;
            r_fill      <= '0;
            r_acc       <= '0;
            r_bit_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_sync_hit  <= 1'b0;
            r_len_err   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_sync_hit <= 1'b0;
            r_len_err  <= 1'b0;

            if (w_out_hs) begin
                r_out_valid <= 1'b0;
                if (r_out_last) begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end
            end

            if (w_accept) begin
                case (r_state)
                    HUNT: begin
                        if (w_match) begin
                            r_sync_hit <= 1'b1;
                            r_state    <= LEN;
                            r_sr       <= '0;
                            r_fill     <= '0;
                            r_bit_cnt  <= '0;
                        end else begin
                            r_sr <= w_cand[30:0];
                            if (r_fill != 6'd32) begin
                                r_fill <= r_fill + 6'd1;
                            end
                        end
                    end
                    LEN: begin
                        r_acc     <= w_next_acc;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (w_len_bad) begin
                                r_len_err <= 1'b1;
                                r_state   <= HUNT;
                            end else begin
                                r_byte_cnt <= w_next_acc;
                                r_state    <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        r_acc     <= w_next_acc;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            // Overrides the handshake clear above: back-to-back bytes, no bubble.
                            r_out_data  <= w_next_acc;
                            r_out_valid <= 1'b1;
                            r_out_last  <= (r_byte_cnt == 8'd1);
                            r_byte_cnt  <= r_byte_cnt - 8'd1;
                            if (r_byte_cnt == 8'd1) begin
                                r_state <= HUNT;
                            end
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign sync_hit  = r_sync_hit;
    assign len_err   = r_len_err;
    assign frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rx_frame_ctrl.sv
// ============================================================================
// Module      : tb_rx_frame_ctrl
// Description : Directed self-checking bench for rx_frame_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_frame_ctrl;

    localparam logic [31:0] SYNC = 32'h1ACF_FC1D;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;
    logic        sync_hit;
    logic        len_err;
    logic [15:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    logic rdy_rand  = 1'b0;
    logic rdy_fixed = 1'b1;
    logic gap_en    = 1'b0;

    logic [7:0] pay[$];
    logic [7:0] exp_q[$];
    logic       expl_q[$];
    logic [7:0] rx_q[$];
    logic       rxl_q[$];

    int n_sync   = 0;
    int n_lenerr = 0;
    int n_ov     = 0;
    int n_stall  = 0;
    int stab_err = 0;
    logic       held_v = 1'b0;
    logic [7:0] held_d = 8'h00;
    logic       held_l = 1'b0;

    rx_frame_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .sync_hit  (sync_hit),
        .len_err   (len_err),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                rx_q.push_back(out_data);
                rxl_q.push_back(out_last);
            end
            if (sync_hit)               n_sync   <= n_sync + 1;
            if (len_err)                n_lenerr <= n_lenerr + 1;
            if (out_valid)              n_ov     <= n_ov + 1;
            if (in_valid && !in_ready)  n_stall  <= n_stall + 1;
            if (held_v && (!out_valid || out_data !== held_d || out_last !== held_l))
                stab_err <= stab_err + 1;
            held_v <= out_valid && !out_ready;
            held_d <= out_data;
            held_l <= out_last;
        end else begin
            held_v <= 1'b0;
        end
    end

    task automatic send_bit(input logic b);
        int n;
        if (gap_en) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        #1;
        n = 0;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL send_bit_timeout: in_ready=%0b required 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Sync, length field, then every byte currently in pay.
    task automatic send_frame(input logic [31:0] sw, input logic [7:0] len);
        send_word(sw);
        send_byte(len);
        for (int i = 0; i < pay.size(); i++) send_byte(pay[i]);
        in_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int t;
        t = 0;
        while (rx_q.size() < n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) begin
            checks++;
            errors++;
            $display("FAIL wait_rx_timeout: got %0d bytes required %0d", rx_q.size(), n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_bytes(input string nm, input int base);
        checks++;
        if (rx_q.size() - base !== exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d required %0d", nm, rx_q.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (rx_q[base+i] !== exp_q[i] || rxl_q[base+i] !== expl_q[i]) begin
                    errors++;
                    $display("FAIL %s_byte%0d: got %h/last=%0b required %h/last=%0b",
                             nm, i, rx_q[base+i], rxl_q[base+i], exp_q[i], expl_q[i]);
                end
            end
        end
    endtask

    task automatic load_pay(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int n);
        logic [7:0] v[4];
        v[0] = b0; v[1] = b1; v[2] = b2; v[3] = b3;
        pay.delete();
        exp_q.delete();
        expl_q.delete();
        for (int i = 0; i < n; i++) begin
            pay.push_back(v[i]);
            exp_q.push_back(v[i]);
            expl_q.push_back(i == n - 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0)     begin errors++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        checks++; if (out_last !== 1'b0)     begin errors++; $display("FAIL rst_out_last: got %b required 0", out_last); end
        checks++; if (out_data !== 8'h00)    begin errors++; $display("FAIL rst_out_data: got %h required 00", out_data); end
        checks++; if (sync_hit !== 1'b0)     begin errors++; $display("FAIL rst_sync_hit: got %b required 0", sync_hit); end
        checks++; if (len_err !== 1'b0)      begin errors++; $display("FAIL rst_len_err: got %b required 0", len_err); end
        checks++; if (frame_cnt !== 16'd0)   begin errors++; $display("FAIL rst_frame_cnt: got %0d required 0", frame_cnt); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1)     begin errors++; $display("FAIL rst_release_in_ready: got %b required 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_basic();
        int rb, sb;
        rb = rx_q.size();
        sb = n_sync;
        rdy_fixed = 1'b1;
        load_pay(8'hA5, 8'h3C, 8'hFF, 8'h00, 3);
        send_frame(SYNC, 8'h03);
        wait_rx(rb + 3);
        check_bytes("basic", rb);
        checks++; if (frame_cnt !== 16'd1)  begin errors++; $display("FAIL basic_frame_cnt: got %0d required 1", frame_cnt); end
        checks++; if (n_sync - sb !== 1)    begin errors++; $display("FAIL basic_sync_hits: got %0d required 1", n_sync - sb); end
    endtask

    task automatic test_sync_errors();
        int rb, sb, lb;
        do_reset();
        rb = rx_q.size();
        sb = n_sync;
        load_pay(8'h5A, 8'h00, 8'h00, 8'h00, 1);
        send_frame(SYNC ^ 32'h0000_0021, 8'h01);
        wait_rx(rb + 1);
        check_bytes("sync2err", rb);
        checks++; if (n_sync - sb !== 1)    begin errors++; $display("FAIL sync2err_hits: got %0d required 1", n_sync - sb); end
        checks++; if (frame_cnt !== 16'd1)  begin errors++; $display("FAIL sync2err_frame_cnt: got %0d required 1", frame_cnt); end
        sb = n_sync;
        lb = n_lenerr;
        send_word(SYNC ^ 32'h0010_0021);
        send_byte(8'h00);
        idle(3);
        checks++; if (n_sync - sb !== 0)    begin errors++; $display("FAIL sync3err_hits: got %0d required 0", n_sync - sb); end
        checks++; if (n_lenerr - lb !== 0)  begin errors++; $display("FAIL sync3err_left_hunt: len_err pulses %0d required 0", n_lenerr - lb); end
    endtask

    task automatic test_len_err();
        int lb, ob, rb;
        do_reset();
        lb = n_lenerr;
        ob = n_ov;
        pay.delete();
        send_frame(SYNC, 8'h00);
        idle(3);
        checks++; if (n_lenerr - lb !== 1)  begin errors++; $display("FAIL len0_err: got %0d pulses required 1", n_lenerr - lb); end
        send_frame(SYNC, 8'(256));
        idle(3);
        checks++; if (n_lenerr - lb !== 2)  begin errors++; $display("FAIL len256_err: got %0d pulses required 2", n_lenerr - lb); end
        checks++; if (n_ov - ob !== 0)      begin errors++; $display("FAIL lenerr_out_valid: got %0d cycles required 0", n_ov - ob); end
        rb = rx_q.size();
        load_pay(8'h11, 8'h22, 8'h00, 8'h00, 2);
        send_frame(SYNC, 8'h02);
        wait_rx(rb + 2);
        check_bytes("lenerr_next", rb);
        checks++; if (frame_cnt !== 16'd1)  begin errors++; $display("FAIL lenerr_frame_cnt: got %0d required 1", frame_cnt); end
    endtask

    task automatic test_backpressure();
        int rb, stb, seb, t;
        do_reset();
        rdy_fixed = 1'b0;
        @(negedge clk);
        rb  = rx_q.size();
        stb = n_stall;
        seb = stab_err;
        load_pay(8'h12, 8'h34, 8'h56, 8'h78, 4);
        fork
            send_frame(SYNC, 8'h04);
            begin
                t = 0;
                while (out_valid !== 1'b1 && t < 2000) begin
                    @(negedge clk);
                    t++;
                end
                repeat (20) @(negedge clk);
                rdy_fixed = 1'b1;
            end
        join
        wait_rx(rb + 4);
        check_bytes("bp", rb);
        checks++; if (n_stall - stb <= 0)   begin errors++; $display("FAIL bp_in_ready_drop: stall cycles %0d required >0", n_stall - stb); end
        checks++; if (stab_err - seb !== 0) begin errors++; $display("FAIL bp_hold_stable: got %0d changes required 0", stab_err - seb); end
        checks++; if (frame_cnt !== 16'd1)  begin errors++; $display("FAIL bp_frame_cnt: got %0d required 1", frame_cnt); end
    endtask

    task automatic test_reset_midframe();
        int rb, lasts;
        do_reset();
        rdy_fixed = 1'b1;
        rb = rx_q.size();
        send_word(SYNC);
        send_byte(8'h04);
        send_byte(8'hA1);
        send_byte(8'hB2);
        idle(3);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL mid_rst_out_valid: got %b required 0", out_valid); end
        checks++; if (out_last !== 1'b0)    begin errors++; $display("FAIL mid_rst_out_last: got %b required 0", out_last); end
        checks++; if (out_data !== 8'h00)   begin errors++; $display("FAIL mid_rst_out_data: got %h required 00", out_data); end
        checks++; if (in_ready !== 1'b0)    begin errors++; $display("FAIL mid_rst_in_ready: got %b required 0", in_ready); end
        rst = 1'b0;
        lasts = 0;
        for (int i = rb; i < rx_q.size(); i++) if (rxl_q[i]) lasts++;
        checks++; if (rx_q.size() - rb !== 2) begin errors++; $display("FAIL mid_partial_bytes: got %0d required 2", rx_q.size() - rb); end
        checks++; if (lasts !== 0)          begin errors++; $display("FAIL mid_no_last: got %0d last flags required 0", lasts); end
        rb = rx_q.size();
        load_pay(8'h77, 8'h00, 8'h00, 8'h00, 1);
        send_frame(SYNC, 8'h01);
        wait_rx(rb + 1);
        check_bytes("mid_next", rb);
        checks++; if (frame_cnt !== 16'd1)  begin errors++; $display("FAIL mid_frame_cnt: got %0d required 1", frame_cnt); end
    endtask

    task automatic test_back_to_back();
        int rb, n;
        logic [7:0] all_exp[$];
        logic       all_last[$];
        do_reset();
        rb = rx_q.size();
        rdy_rand = 1'b1;
        gap_en   = 1'b1;
        for (int f = 0; f < 100; f++) begin
            n = $urandom_range(1, 4);
            pay.delete();
            for (int i = 0; i < n; i++) begin
                pay.push_back(8'($urandom));
                all_exp.push_back(pay[i]);
                all_last.push_back(i == n - 1);
            end
            send_frame(SYNC, 8'(n));
        end
        gap_en = 1'b0;
        wait_rx(rb + all_exp.size());
        rdy_rand  = 1'b0;
        rdy_fixed = 1'b1;
        repeat (3) @(negedge clk);
        exp_q  = all_exp;
        expl_q = all_last;
        check_bytes("b2b", rb);
        checks++; if (frame_cnt !== 16'd100) begin errors++; $display("FAIL b2b_frame_cnt: got %0d required 100", frame_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 1'b0;
        test_reset();
        test_basic();
        test_sync_errors();
        test_len_err();
        test_backpressure();
        test_reset_midframe();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
